// File: rtl/yarp_rf_pkg.sv
// Shared types and configuration checks for the yarp multi-port register file.
package yarp_rf_pkg;

  typedef enum logic [1:0] {
    DBG_IDLE,
    DBG_ACCESS,
    DBG_ACK
  } dbg_state_e;

  localparam int unsigned X0_ADDR = 0;

  // Only RV32I (32) and RV32E (16) register counts, and 1..4 read ports, are legal.
  function automatic bit rf_cfg_ok(input int num_regs, input int num_rd);
    return ((num_regs == 16) || (num_regs == 32)) && (num_rd >= 1) && (num_rd <= 4);
  endfunction

endpackage

// File: rtl/yarp_rf_dbg_fsm.sv
// Four-phase debug handshake for the register file; yields to core writeback
// and issues one-cycle write/read strobes toward the array.
module yarp_rf_dbg_fsm
  import yarp_rf_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic dbg_req_i,
  input  logic dbg_we_i,
  input  logic wr_en_i,
  output logic dbg_ack_o,
  output logic dbg_wr_stb_o,
  output logic dbg_rd_stb_o
);

  dbg_state_e state_q, state_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= DBG_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    dbg_wr_stb_o = 1'b0;
    dbg_rd_stb_o = 1'b0;
    case (state_q)
      DBG_IDLE: begin
        if (dbg_req_i) state_d = DBG_ACCESS;
      end
      DBG_ACCESS: begin
        if (!wr_en_i) begin
          dbg_wr_stb_o = dbg_we_i;
          dbg_rd_stb_o = !dbg_we_i;
          state_d      = DBG_ACK;
        end
      end
      DBG_ACK: begin
        if (!dbg_req_i) state_d = DBG_IDLE;
      end
      default: state_d = DBG_IDLE;
    endcase
  end

  assign dbg_ack_o = (state_q == DBG_ACK);

endmodule

// File: rtl/yarp_regfile_mp.sv
// Multi-port integer register file with pending-write scoreboard and debug port.
// Optional same-cycle write bypass on the read ports: define YARP_RF_BYPASS_EN.
module yarp_regfile_mp
  import yarp_rf_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  parameter  int NUM_RD   = 2,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rs_addr_i,
  output logic [NUM_RD*DATA_W-1:0]   rs_data_o,
  output logic [NUM_RD-1:0]          rs_busy_o,
  input  logic                       wr_en_i,
  input  logic [ADDR_W-1:0]          rd_addr_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       sb_set_i,
  input  logic [ADDR_W-1:0]          sb_addr_i,
  input  logic                       dbg_req_i,
  input  logic                       dbg_we_i,
  input  logic [ADDR_W-1:0]          dbg_addr_i,
  input  logic [DATA_W-1:0]          dbg_wdata_i,
  output logic                       dbg_ack_o,
  output logic [DATA_W-1:0]          dbg_rdata_o
);

  if (!rf_cfg_ok(NUM_REGS, NUM_RD)) begin : g_cfg_err
    $error("yarp_regfile_mp: NUM_REGS must be 16 or 32 and NUM_RD 1..4");
  end

  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(X0_ADDR);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] sb_q, sb_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic dbg_wr_stb, dbg_rd_stb;
  logic core_wr;

  yarp_rf_dbg_fsm u_dbg_fsm (
    .clk          (clk),
    .reset_n      (reset_n),
    .dbg_req_i    (dbg_req_i),
    .dbg_we_i     (dbg_we_i),
    .wr_en_i      (wr_en_i),
    .dbg_ack_o    (dbg_ack_o),
    .dbg_wr_stb_o (dbg_wr_stb),
    .dbg_rd_stb_o (dbg_rd_stb)
  );

  assign core_wr = wr_en_i && (rd_addr_i != X0);

  // The debug strobe only fires when wr_en_i is low, so the two writers never collide.
  always_comb begin
    regs_d = regs_q;
    if (dbg_wr_stb && (dbg_addr_i != X0)) regs_d[dbg_addr_i] = dbg_wdata_i;
    if (core_wr) regs_d[rd_addr_i] = wr_data_i;
    regs_d[X0_ADDR] = '0;
  end

  always_comb begin
    sb_d = sb_q;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (sb_set_i && (sb_addr_i == ADDR_W'(i)))     sb_d[i] = 1'b1;
      else if (wr_en_i && (rd_addr_i == ADDR_W'(i))) sb_d[i] = 1'b0;
    end
    sb_d[X0_ADDR] = 1'b0;
  end

  always_comb begin
    dbg_rdata_d = dbg_rdata_q;
    if (dbg_rd_stb) dbg_rdata_d = regs_q[dbg_addr_i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs_q      <= '{default: '0};
      sb_q        <= '0;
      dbg_rdata_q <= '0;
    end else begin
      regs_q      <= regs_d;
      sb_q        <= sb_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign dbg_rdata_o = dbg_rdata_q;

  always_comb begin
    logic [ADDR_W-1:0] addr;
    rs_data_o = '0;
    rs_busy_o = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      addr = rs_addr_i[k*ADDR_W +: ADDR_W];
      rs_data_o[k*DATA_W +: DATA_W] = regs_q[addr];
      rs_busy_o[k]                  = sb_q[addr];
`ifdef YARP_RF_BYPASS_EN
      if (core_wr && (rd_addr_i == addr)) begin
        rs_data_o[k*DATA_W +: DATA_W] = wr_data_i;
        rs_busy_o[k]                  = sb_set_i && (sb_addr_i == addr);
      end
`endif
    end
  end

endmodule

// File: tb/tb_yarp_regfile_mp.sv
// Self-checking bench for yarp_regfile_mp: directed scenarios followed by
// randomized core traffic, checked against an array/scoreboard reference model.
module tb_yarp_regfile_mp;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int RD = 2;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [RD*AW-1:0] rs_addr;
  logic [RD*DW-1:0] rs_data;
  logic [RD-1:0]    rs_busy;
  logic            wr_en;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   wr_data;
  logic            sb_set;
  logic [AW-1:0]   sb_addr;
  logic            dbg_req;
  logic            dbg_we;
  logic [AW-1:0]   dbg_addr;
  logic [DW-1:0]   dbg_wdata;
  logic            dbg_ack;
  logic [DW-1:0]   dbg_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] m_regs [NR];
  bit            m_sb   [NR];
  logic [DW-1:0] m_rdata;

  yarp_regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(RD)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rs_addr_i   (rs_addr),
    .rs_data_o   (rs_data),
    .rs_busy_o   (rs_busy),
    .wr_en_i     (wr_en),
    .rd_addr_i   (rd_addr),
    .wr_data_i   (wr_data),
    .sb_set_i    (sb_set),
    .sb_addr_i   (sb_addr),
    .dbg_req_i   (dbg_req),
    .dbg_we_i    (dbg_we),
    .dbg_addr_i  (dbg_addr),
    .dbg_wdata_i (dbg_wdata),
    .dbg_ack_o   (dbg_ack),
    .dbg_rdata_o (dbg_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_sb[i]   = 1'b0;
    end
    m_rdata = '0;
  endtask

  // Reference: stored value / pending bit, with same-cycle writeback forwarding when enabled.
  task automatic check_ports(input string tag);
    for (int k = 0; k < RD; k++) begin
      int a;
      logic [DW-1:0] ed;
      logic eb;
      a  = int'(rs_addr[k*AW +: AW]);
      ed = m_regs[a];
      eb = m_sb[a];
`ifdef YARP_RF_BYPASS_EN
      if (wr_en && rd_addr != 0 && int'(rd_addr) == a) begin
        ed = wr_data;
        eb = sb_set && int'(sb_addr) == a;
      end
`endif
      chk($sformatf("%s_data%0d", tag, k), 64'(rs_data[k*DW +: DW]), 64'(ed));
      chk($sformatf("%s_busy%0d", tag, k), 64'(rs_busy[k]), 64'(eb));
    end
  endtask

  task automatic tick();
    if (wr_en && rd_addr != 0) m_regs[rd_addr] = wr_data;
    if (wr_en) m_sb[rd_addr] = 1'b0;
    if (sb_set && sb_addr != 0) m_sb[sb_addr] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_rs(input int a0, input int a1);
    rs_addr[0 +: AW]  = AW'(a0);
    rs_addr[AW +: AW] = AW'(a1);
  endtask

  task automatic core_idle();
    wr_en = 1'b0; rd_addr = '0; wr_data = '0; sb_set = 1'b0; sb_addr = '0;
  endtask

  initial begin
    logic [DW-1:0] byp_exp;
    reset_n = 1'b0;
    core_idle();
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    set_rs(5, 9);
    model_reset();
    #2;
    check_ports("in_reset");
    chk("in_reset_ack", 64'(dbg_ack), 64'(0));
    chk("in_reset_rdata", 64'(dbg_rdata), 64'(0));
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset clears registers, scoreboard and debug outputs.
    wr_en = 1'b1; rd_addr = 5; wr_data = 32'hDEADBEEF; sb_set = 1'b1; sb_addr = 6;
    set_rs(5, 6);
    #1 check_ports("pre_w5");
    tick();
    core_idle();
    #1 check_ports("w5");
    chk("w5_value", 64'(rs_data[0 +: DW]), 64'(32'hDEADBEEF));
    reset_n = 1'b0; #2 reset_n = 1'b1;
    model_reset();
    #1 check_ports("post_rst");
    chk("post_rst_x5", 64'(rs_data[0 +: DW]), 64'(0));
    chk("post_rst_busy", 64'(rs_busy), 64'(0));
    chk("post_rst_ack", 64'(dbg_ack), 64'(0));
    chk("post_rst_rdata", 64'(dbg_rdata), 64'(0));

    // x0 ignores writes and scoreboard sets.
    wr_en = 1'b1; rd_addr = 0; wr_data = 32'hFFFFFFFF; sb_set = 1'b1; sb_addr = 0;
    set_rs(0, 0);
    #1 check_ports("x0_wr");
    tick();
    core_idle();
    #1 check_ports("x0");
    chk("x0_data", 64'(rs_data), 64'(0));
    chk("x0_busy", 64'(rs_busy), 64'(0));

    // Same-cycle write/read of x7.
    wr_en = 1'b1; rd_addr = 7; wr_data = 32'h11111111;
    tick();
    wr_data = 32'h12345678;
    set_rs(3, 7);
`ifdef YARP_RF_BYPASS_EN
    byp_exp = 32'h12345678;
`else
    byp_exp = 32'h11111111;
`endif
    #1 check_ports("byp");
    chk("byp_x7", 64'(rs_data[DW +: DW]), 64'(byp_exp));
    tick();
    core_idle();
    #1 chk("x7_after", 64'(rs_data[DW +: DW]), 64'(32'h12345678));

    // Scoreboard set, clear and set-wins.
    sb_set = 1'b1; sb_addr = 3; set_rs(3, 3);
    tick();
    sb_set = 1'b0;
    #1 chk("sb_set_x3", 64'(rs_busy[0]), 64'(1));
    wr_en = 1'b1; rd_addr = 3; wr_data = 32'h33;
    #1 check_ports("sb_clr_cyc");
    tick();
    core_idle();
    #1 chk("sb_clr_x3", 64'(rs_busy[0]), 64'(0));
    wr_en = 1'b1; rd_addr = 3; wr_data = 32'h44; sb_set = 1'b1; sb_addr = 3;
    #1 check_ports("sb_both_cyc");
    tick();
    core_idle();
    #1 chk("sb_set_wins", 64'(rs_busy[0]), 64'(1));
    check_ports("sb_both");
    wr_en = 1'b1; rd_addr = 3; wr_data = 32'h55;
    tick();
    core_idle();

    // Debug write of x9, no conflict: ack in cycle 2, value visible in cycle 2.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9; dbg_wdata = 32'hA5A5A5A5;
    set_rs(9, 0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("dw9_ack_c%0d", c), 64'(dbg_ack), 64'(c == 2));
      check_ports($sformatf("dw9_c%0d", c));
      if (c == 2) chk("dw9_x9", 64'(rs_data[0 +: DW]), 64'(32'hA5A5A5A5));
      if (c >= 2) dbg_req = 1'b0;
      tick();
      if (c == 1) m_regs[9] = 32'hA5A5A5A5;
    end

    // Debug write of x10 while core writes x4 for 3 ACCESS cycles: ack in cycle 5.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10; dbg_wdata = 32'h5A5A5A5A;
    set_rs(10, 4);
    for (int c = 0; c < 8; c++) begin
      wr_en = (c >= 1 && c <= 3); rd_addr = 4; wr_data = $urandom;
      dbg_req = (c <= 5);
      #1;
      chk($sformatf("dw10_ack_c%0d", c), 64'(dbg_ack), 64'(c >= 5 && c <= 6));
      check_ports($sformatf("dw10_c%0d", c));
      if (c == 5) chk("dw10_x10", 64'(rs_data[0 +: DW]), 64'(32'h5A5A5A5A));
      tick();
      if (c == 4) m_regs[10] = 32'h5A5A5A5A;
    end
    core_idle();

    // Debug read of x9 with a long-held request.
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9; dbg_wdata = 32'h0BADF00D;
    for (int c = 0; c < 8; c++) begin
      dbg_req = (c <= 5);
      #1;
      chk($sformatf("dr9_ack_c%0d", c), 64'(dbg_ack), 64'(c >= 2 && c <= 6));
      chk($sformatf("dr9_rdata_c%0d", c), 64'(dbg_rdata), 64'(m_rdata));
      check_ports($sformatf("dr9_c%0d", c));
      tick();
      if (c == 1) m_rdata = 32'hA5A5A5A5;
    end
    chk("dr9_rdata_final", 64'(dbg_rdata), 64'(32'hA5A5A5A5));

    // Reset during ACCESS aborts the debug write.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 11; dbg_wdata = 32'hCAFEF00D;
    set_rs(11, 9);
    tick();
    dbg_req = 1'b0;
    reset_n = 1'b0; #2 reset_n = 1'b1;
    model_reset();
    tick();
    tick();
    #1;
    check_ports("abort");
    chk("abort_x11", 64'(rs_data[0 +: DW]), 64'(0));
    chk("abort_ack", 64'(dbg_ack), 64'(0));
    chk("abort_rdata", 64'(dbg_rdata), 64'(0));

    // Randomized core traffic.
    for (int n = 0; n < 300; n++) begin
      wr_en   = ($urandom_range(0, 1) == 1);
      rd_addr = AW'($urandom_range(0, NR - 1));
      wr_data = $urandom;
      sb_set  = ($urandom_range(0, 2) == 0);
      sb_addr = ($urandom_range(0, 3) == 0) ? rd_addr : AW'($urandom_range(0, NR - 1));
      if ($urandom_range(0, 3) == 0) set_rs(int'(rd_addr), $urandom_range(0, NR - 1));
      else set_rs($urandom_range(0, NR - 1), $urandom_range(0, NR - 1));
      #1;
      check_ports($sformatf("rnd%0d", n));
      chk($sformatf("rnd%0d_ack", n), 64'(dbg_ack), 64'(0));
      tick();
    end
    core_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
